// File: rtl/axil_cmd_master_pkg.sv
// Shared definitions for axil_cmd_master: FSM encodings, AXI response codes,
// default watchdog limit and the captured-response record.
package axil_cmd_master_pkg;

  localparam int unsigned DATA_W             = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_WB   = 3'd2;
  localparam logic [2:0] ST_RA   = 3'd3;
  localparam logic [2:0] ST_RD   = 3'd4;
  localparam logic [2:0] ST_RSP  = 3'd5;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [1:0]        resp;
    logic              timeout;
  } rsp_t;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding command master: turns one command at a time
// into an AW/W/B or AR/R sequence and returns the captured response.
// Optional watchdog enabled by defining AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  logic [2:0]            state_q,     state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q,   awvalid_d;
  logic                  wvalid_q,    wvalid_d;
  logic                  bready_q,    bready_d;
  logic                  arvalid_q,   arvalid_d;
  logic                  rready_q,    rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0]     wdata_q,     wdata_d;
  rsp_t                  rsp_q,       rsp_d;
  logic                  aw_ok_c,     w_ok_c;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             busy_c;
  logic             to_hit_c;

  assign busy_c   = (state_q == ST_WR) || (state_q == ST_WB) ||
                    (state_q == ST_RA) || (state_q == ST_RD);
  assign to_hit_c = busy_c && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent waiting on the slave, cleared whenever idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_cnt_q <= '0;
    end else if (!busy_c) begin
      to_cnt_q <= '0;
    end else if (!to_hit_c) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-output logic; every output is a register fed from here.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_d       = rsp_q;
    aw_ok_c     = 1'b0;
    w_ok_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_write) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RA;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        // A channel already dropped its valid once its handshake completed.
        aw_ok_c = !awvalid_q || awready;
        w_ok_c  = !wvalid_q || wready;
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_ok_c && w_ok_c) begin
          state_d  = ST_WB;
          bready_d = 1'b1;
        end
      end
      ST_WB: begin
        if (bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_d       = '{rdata: '0, resp: bresp, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RA: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD;
        end
      end
      ST_RD: begin
        if (rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_d       = '{rdata: rdata, resp: rresp, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // Abandon the transaction: release every channel and report SLVERR.
    if (to_hit_c) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_d       = '{rdata: '0, resp: RESP_SLVERR, timeout: 1'b1};
      rsp_valid_d = 1'b1;
      state_d     = ST_RSP;
    end
`endif

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_q       <= '{rdata: '0, resp: RESP_OKAY, timeout: 1'b0};
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_resp    = rsp_q.resp;
  assign rsp_timeout = rsp_q.timeout;
  assign awaddr      = addr_q;
  assign awprot      = 3'b000;
  assign awvalid     = awvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = 4'hF;
  assign wvalid      = wvalid_q;
  assign bready      = bready_q;
  assign araddr      = addr_q;
  assign arprot      = 3'b000;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed testbench for axil_cmd_master; the slave side is driven by hand
// from each scenario task.
module tb_axil_cmd_master;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_pass  = 0;
  int n_total = 0;

  axil_cmd_master #(.ADDR_WIDTH(5), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic test_reset();
    @(negedge aclk);
    n_total++;
    if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 7'b0)
      $display("FAIL reset_ctrl got=%b exp=0000000", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid});
    else n_pass++;
    n_total++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0)
      $display("FAIL reset_rsp got=%h exp=0", {rsp_rdata, rsp_resp, rsp_timeout});
    else n_pass++;
    aresetn = 1'b1;
    tick();
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h10; cmd_wdata = 32'hFFFF_FFFF;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL rd_cmd_ready got=%b exp=1", cmd_ready);
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    n_total++;
    if ({arvalid, araddr, arprot} !== {1'b1, 5'h10, 3'b000})
      $display("FAIL rd_ar got=%h exp=%h", {arvalid, araddr, arprot}, {1'b1, 5'h10, 3'b000});
    else n_pass++;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    n_total++;
    if ({arvalid, rready} !== 2'b01) $display("FAIL rd_ar_done got=%b exp=01", {arvalid, rready});
    else n_pass++;
    repeat (2) tick();
    n_total++;
    if ({rready, rsp_valid} !== 2'b10) $display("FAIL rd_wait got=%b exp=10", {rready, rsp_valid});
    else n_pass++;
    rvalid = 1'b1; rdata = 32'h0000_0007; rresp = 2'b10;
    tick();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    n_total++;
    if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, rready} !== {1'b1, 32'h7, 2'b10, 1'b0, 1'b0})
      $display("FAIL rd_rsp got=%h exp=%h", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, rready},
               {1'b1, 32'h7, 2'b10, 1'b0, 1'b0});
    else n_pass++;
    tick();
    n_total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL rd_done got=%b exp=01", {rsp_valid, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_write_zero_wait(input logic [4:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready got=%b exp=1", cmd_ready);
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    n_total++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb, awprot, rsp_valid} !== {2'b11, a, d, 4'hF, 3'b000, 1'b0})
      $display("FAIL wr_aw_w got=%h exp=%h", {awvalid, wvalid, awaddr, wdata, wstrb, awprot, rsp_valid},
               {2'b11, a, d, 4'hF, 3'b000, 1'b0});
    else n_pass++;
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    n_total++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010)
      $display("FAIL wr_wb got=%b exp=0010", {awvalid, wvalid, bready, rsp_valid});
    else n_pass++;
    tick();
    bvalid = 1'b0;
    n_total++;
    if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, bready} !== {1'b1, 32'h0, 2'b00, 1'b0, 1'b0})
      $display("FAIL wr_rsp_cycle3 got=%h exp=%h", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, bready},
               {1'b1, 32'h0, 2'b00, 1'b0, 1'b0});
    else n_pass++;
    tick();
    n_total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL wr_done got=%b exp=01", {rsp_valid, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_write_wdelay();
    int bad = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h08; cmd_wdata = 32'h1234_5678;
    tick();
    cmd_valid = 1'b0;
    awready = 1'b1;
    tick();
    awready = 1'b0;
    n_total++;
    if ({awvalid, wvalid, wdata} !== {2'b01, 32'h1234_5678})
      $display("FAIL wd_aw_first got=%h exp=%h", {awvalid, wvalid, wdata}, {2'b01, 32'h1234_5678});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if ({awvalid, wvalid, bready} !== 3'b010) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL wd_w_held got=%0d bad cycles exp=0", bad);
    else n_pass++;
    wready = 1'b1;
    tick();
    wready = 1'b0; bvalid = 1'b1; bresp = 2'b11;
    n_total++;
    if ({wvalid, bready} !== 2'b01) $display("FAIL wd_wb got=%b exp=01", {wvalid, bready});
    else n_pass++;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    n_total++;
    if ({rsp_valid, rsp_resp, rsp_timeout, bready} !== {1'b1, 2'b11, 1'b0, 1'b0})
      $display("FAIL wd_rsp_decerr got=%b exp=%b", {rsp_valid, rsp_resp, rsp_timeout, bready}, 5'b11100);
    else n_pass++;
    tick();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if ({rsp_valid, bready, cmd_ready} !== 3'b001) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL wd_single_rsp got=%0d bad cycles exp=0", bad);
    else n_pass++;
  endtask

  task automatic test_rsp_backpressure();
    int bad = 0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h0C;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hA5A5_0001; rresp = 2'b01;
    tick();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) rsp_ready = 1'b1;
      if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready} !== {1'b1, 32'hA5A5_0001, 2'b01, 1'b0, 1'b0})
        bad++;
      if (i < 4) tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL bp_rsp_stable got=%0d bad cycles exp=0", bad);
    else n_pass++;
    tick();
    n_total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL bp_cmd_ready_after got=%b exp=01", {rsp_valid, cmd_ready});
    else n_pass++;
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int bad = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h14;
    tick();
    cmd_valid = 1'b0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      if ({arvalid, rsp_valid} !== 2'b10) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL to_ar_held got=%0d bad cycles exp=0", bad);
    else n_pass++;
    n_total++;
    if ({arvalid, rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {4'b0011, 2'b10, 32'h0})
      $display("FAIL to_abandon got=%h exp=%h", {arvalid, rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
               {4'b0011, 2'b10, 32'h0});
    else n_pass++;
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      if ({arvalid, rsp_valid, rsp_timeout} !== 3'b100) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL to_ar_waits got=%0d bad cycles exp=0", bad);
    else n_pass++;
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_1234; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    n_total++;
    if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h1234})
      $display("FAIL to_late_rsp got=%h exp=%h", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
               {2'b10, 2'b00, 32'h1234});
    else n_pass++;
    tick();
`endif
    n_total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL to_done got=%b exp=01", {rsp_valid, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_reset_in_wb();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h18; cmd_wdata = 32'hCAFE_F00D;
    tick();
    cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    n_total++;
    if (bready !== 1'b1) $display("FAIL rwb_in_wb got=%b exp=1", bready);
    else n_pass++;
    #1 aresetn = 1'b0;
    #1;
    n_total++;
    if ({bready, cmd_ready, rsp_valid, awvalid, wvalid} !== 5'b0)
      $display("FAIL rwb_async got=%b exp=00000", {bready, cmd_ready, rsp_valid, awvalid, wvalid});
    else n_pass++;
    bvalid = 1'b1; bresp = 2'b10;
    @(negedge aclk);
    aresetn = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    tick();
    n_total++;
    if ({cmd_ready, rsp_valid, bready} !== 3'b100)
      $display("FAIL rwb_release got=%b exp=100", {cmd_ready, rsp_valid, bready});
    else n_pass++;
    test_write_zero_wait(5'h1C, 32'h55AA_55AA);
  endtask

  initial begin
    aresetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 5'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    test_reset();
    test_read();
    test_write_zero_wait(5'h04, 32'hDEAD_BEEF);
    test_write_wdelay();
    test_rsp_backpressure();
    test_timeout();
    test_reset_in_wb();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master
Interface
REQ-001 ADDR_WIDTH, 5, AXI-Lite byte address width.
REQ-002 TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only under AXIL_CMD_MASTER_TIMEOUT_EN.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted on cmd_valid&cmd_ready.
REQ-007 cmd_write  input  1  1=write, 0=read.
REQ-008 cmd_addr  input  ADDR_WIDTH  target register byte address.
REQ-009 cmd_wdata  input  32  write data; ignored for reads.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed on rsp_valid&rsp_ready.
REQ-012 rsp_rdata  output  32  captured rdata; 0 for writes.
REQ-013 rsp_resp  output  2  captured bresp or rresp.
REQ-014 rsp_timeout  output  1  transaction abandoned by watchdog.
REQ-015 awaddr  output  ADDR_WIDTH  write address.
REQ-016 awprot  output  3  constant 3'b000.
REQ-017 awvalid  output  1  write address valid.
REQ-018 awready  input  1  write address accepted.
REQ-019 wdata  output  32  write data.
REQ-020 wstrb  output  4  constant 4'hF.
REQ-021 wvalid  output  1  write data valid.
REQ-022 wready  input  1  write data accepted.
REQ-023 bresp  input  2  write response code.
REQ-024 bvalid  input  1  write response valid.
REQ-025 bready  output  1  write response accepted.
REQ-026 araddr  output  ADDR_WIDTH  read address.
REQ-027 arprot  output  3  constant 3'b000.
REQ-028 arvalid  output  1  read address valid.
REQ-029 arready  input  1  read address accepted.
REQ-030 rdata  input  32  read data.
REQ-031 rresp  input  2  read response code.
REQ-032 rvalid  input  1  read data valid.
REQ-033 rready  output  1  read data accepted.
Function
REQ-034 FSM states IDLE, WR, WB, RA, RD, RSP; cmd_ready=1 only in IDLE; the cmd handshake latches addr/wdata/write and moves to WR (write) or RA (read).
REQ-035 WR: awvalid and wvalid rise the cycle after the cmd handshake, each held with stable payload until its own ready; AW and W may complete in the same or different cycles, in either order; the state moves to WB once both are accepted.
REQ-036 WB: bready=1; bvalid&bready captures bresp, sets rsp_rdata=0 and moves to RSP; RA: arvalid held until arready, then RD; RD: rready=1; rvalid&rready captures rdata/rresp and moves to RSP.
REQ-037 RSP: rsp_valid=1 with rsp_* stable until rsp_ready, then IDLE; with a zero-wait slave and rsp_ready=1, rsp_valid rises exactly 3 cycles after the cmd handshake for both reads and writes.
REQ-038 Valids never depend combinationally on readies; bready/rready are low outside WB/RD; bvalid/rvalid outside WB/RD are ignored; all outputs are registered.
REQ-039 bresp/rresp SLVERR/DECERR are passed through unchanged with rsp_timeout=0; the block performs no retry.
Reset
REQ-040 aresetn low asynchronously forces IDLE and drives all AXI valids/readies, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout and cmd_ready to 0; cmd_ready=1 from the first clock edge after release; a transaction in flight is dropped with no response.
Configuration
REQ-041 AXIL_CMD_MASTER_TIMEOUT_EN defined: a counter clears on leaving IDLE and increments each cycle in WR/WB/RA/RD; when it reaches TIMEOUT_CYCLES, all AXI valids/readies drop and the state moves to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0. Undefined: no counter; the block waits indefinitely and rsp_timeout is tied to 0.
Structure
REQ-042 Package axil_cmd_master_pkg holds the state enum, the OKAY/EXOKAY/SLVERR/DECERR constants and the default TIMEOUT_CYCLES; no sub-module; single-FSM implementation.
Verification
REQ-043 Write 0x04 <- 0xDEADBEEF, zero-wait slave -> awaddr=0x04, wdata=0xDEADBEEF, wstrb=4'hF; rsp_valid 3 cycles after cmd, rsp_resp=0, rsp_rdata=0.
REQ-044 wready delayed 5 cycles after awready -> awvalid drops after awready; wvalid held 5 more cycles; single B handshake; one response.
REQ-045 Read 0x10, slave returns 0x00000007 with rresp=2'b10 after 2 wait cycles -> rsp_rdata=0x7, rsp_resp=2'b10, rsp_timeout=0.
REQ-046 rsp_ready low for 4 cycles with cmd_valid high -> rsp_* stable, cmd_ready=0 until one cycle after the rsp handshake.
REQ-047 TIMEOUT_EN with TIMEOUT_CYCLES=8, slave never asserts arready -> arvalid drops after 8 cycles; rsp_timeout=1, rsp_resp=2'b10; without the macro, arvalid stays high.
REQ-048 aresetn pulsed during WB -> bready=0 immediately; no rsp_valid; cmd_ready=1 after release; the next write completes normally.
